// File: rtl/billing_cycle_scheduler.sv
// billing_cycle_scheduler: sequences one billing run over meters 0..NUM_METERS-1.
// It issues one request per meter to the shared bill-amount datapath. It accumulates
// a saturating total, a bill count and an overdue count for the operator console.
// Optional feature macro: OVERDUE_PENALTY_EN. When it is defined, PENALTY is added to
// every overdue bill before accumulation.
module billing_cycle_scheduler #(
  parameter int unsigned NUM_METERS  = 10,
  parameter logic [15:0] PENALTY     = 16'd50,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic        i_abort,
  output logic        o_calc_req,
  output logic [3:0]  o_calc_idx,
  input  logic        i_calc_ack,
  input  logic        i_calc_done,
  input  logic [15:0] i_calc_amount,
  input  logic        i_calc_overdue,
  output logic        o_busy,
  output logic        o_run_done,
  output logic        o_aborted,
  output logic [23:0] o_total_amount,
  output logic [3:0]  o_bills_issued,
  output logic [3:0]  o_overdue_cnt
);

  localparam int unsigned IDX_W = 4;
  localparam int unsigned AMT_W = 16;
  localparam int unsigned ADD_W = AMT_W + 1;
  localparam int unsigned TOT_W = 24;
  localparam int unsigned TMO_W = 8;

  localparam logic [IDX_W-1:0] LP_LAST_IDX = IDX_W'(NUM_METERS - 1);
  localparam logic [TMO_W-1:0] LP_TIMEOUT  = TMO_W'(TIMEOUT_CYC);

`ifdef OVERDUE_PENALTY_EN
  localparam bit LP_PENALTY_EN = 1'b1;
`else
  localparam bit LP_PENALTY_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ISSUE  = 3'd1,
    S_WAIT   = 3'd2,
    S_ACCUM  = 3'd3,
    S_FINISH = 3'd4
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               r_calc_req,   w_calc_req_nxt;
  logic [IDX_W-1:0]   r_calc_idx,   w_calc_idx_nxt;
  logic               r_busy,       w_busy_nxt;
  logic               r_run_done,   w_run_done_nxt;
  logic               r_aborted,    w_aborted_nxt;
  logic [TOT_W-1:0]   r_total,      w_total_nxt;
  logic [IDX_W-1:0]   r_bills,      w_bills_nxt;
  logic [IDX_W-1:0]   r_ovd_cnt,    w_ovd_cnt_nxt;
  logic [TMO_W-1:0]   r_tmo_cnt,    w_tmo_cnt_nxt;
  logic [AMT_W-1:0]   r_amount,     w_amount_nxt;
  logic               r_overdue,    w_overdue_nxt;

  logic               w_advance;
  logic [TMO_W-1:0]   w_tmo_inc;
  logic [ADD_W-1:0]   w_addend;
  logic [TOT_W:0]     w_sum;
  logic [TOT_W-1:0]   w_total_sat;

  // Value added for the held bill (penalty only on overdue bills when enabled), saturating sum
  always_comb begin
    w_addend    = {1'b0, r_amount};
    if (LP_PENALTY_EN && r_overdue) begin
      w_addend  = ADD_W'({1'b0, r_amount} + {1'b0, PENALTY});
    end
    w_sum       = {1'b0, r_total} + (TOT_W + 1)'(w_addend);
    w_total_sat = w_sum[TOT_W] ? {TOT_W{1'b1}} : w_sum[TOT_W-1:0];
    w_tmo_inc   = r_tmo_cnt + TMO_W'(1);
  end

  // Next-state and next-register values; abort overrides every non-idle transition
  always_comb begin
    w_state_nxt    = r_state;
    w_calc_idx_nxt = r_calc_idx;
    w_busy_nxt     = r_busy;
    w_run_done_nxt = 1'b0;
    w_aborted_nxt  = r_aborted;
    w_total_nxt    = r_total;
    w_bills_nxt    = r_bills;
    w_ovd_cnt_nxt  = r_ovd_cnt;
    w_tmo_cnt_nxt  = r_tmo_cnt;
    w_amount_nxt   = r_amount;
    w_overdue_nxt  = r_overdue;
    w_advance      = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (i_start && !i_abort) begin
          w_total_nxt    = '0;
          w_bills_nxt    = '0;
          w_ovd_cnt_nxt  = '0;
          w_aborted_nxt  = 1'b0;
          w_calc_idx_nxt = '0;
          w_tmo_cnt_nxt  = '0;
          w_busy_nxt     = 1'b1;
          w_state_nxt    = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (i_calc_ack) begin
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        // A result arriving on the timeout cycle still counts
        if (i_calc_done) begin
          w_amount_nxt  = i_calc_amount;
          w_overdue_nxt = i_calc_overdue;
          w_state_nxt   = S_ACCUM;
        end else if (w_tmo_inc == LP_TIMEOUT) begin
          w_aborted_nxt = 1'b1;
          w_advance     = 1'b1;
        end else begin
          w_tmo_cnt_nxt = w_tmo_inc;
        end
      end
      S_ACCUM: begin
        w_total_nxt   = w_total_sat;
        w_bills_nxt   = r_bills + IDX_W'(1);
        w_ovd_cnt_nxt = r_ovd_cnt + IDX_W'(r_overdue);
        w_advance     = 1'b1;
      end
      S_FINISH: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    // Move to the next meter, or close the run after the last one
    if (w_advance) begin
      w_tmo_cnt_nxt = '0;
      if (r_calc_idx == LP_LAST_IDX) begin
        w_state_nxt    = S_FINISH;
        w_run_done_nxt = 1'b1;
        w_busy_nxt     = 1'b0;
      end else begin
        w_calc_idx_nxt = r_calc_idx + IDX_W'(1);
        w_state_nxt    = S_ISSUE;
      end
    end

    // run_done has already pulsed when abort lands in FINISH, so no second pulse there
    if (i_abort && (r_state != S_IDLE)) begin
      w_state_nxt    = S_IDLE;
      w_busy_nxt     = 1'b0;
      w_aborted_nxt  = 1'b1;
      w_run_done_nxt = (r_state != S_FINISH);
      w_tmo_cnt_nxt  = '0;
    end

    w_calc_req_nxt = (w_state_nxt == S_ISSUE);
  end

  // State and output registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_calc_req <= 1'b0;
      r_calc_idx <= '0;
      r_busy     <= 1'b0;
      r_run_done <= 1'b0;
      r_aborted  <= 1'b0;
      r_total    <= '0;
      r_bills    <= '0;
      r_ovd_cnt  <= '0;
      r_tmo_cnt  <= '0;
      r_amount   <= '0;
      r_overdue  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_calc_req <= w_calc_req_nxt;
      r_calc_idx <= w_calc_idx_nxt;
      r_busy     <= w_busy_nxt;
      r_run_done <= w_run_done_nxt;
      r_aborted  <= w_aborted_nxt;
      r_total    <= w_total_nxt;
      r_bills    <= w_bills_nxt;
      r_ovd_cnt  <= w_ovd_cnt_nxt;
      r_tmo_cnt  <= w_tmo_cnt_nxt;
      r_amount   <= w_amount_nxt;
      r_overdue  <= w_overdue_nxt;
    end
  end

  assign o_calc_req     = r_calc_req;
  assign o_calc_idx     = r_calc_idx;
  assign o_busy         = r_busy;
  assign o_run_done     = r_run_done;
  assign o_aborted      = r_aborted;
  assign o_total_amount = r_total;
  assign o_bills_issued = r_bills;
  assign o_overdue_cnt  = r_ovd_cnt;

endmodule

// File: tb/tb_billing_cycle_scheduler.sv
// Directed bench for billing_cycle_scheduler: a 10-meter instance (A) and a 15-meter instance (B).
module tb_billing_cycle_scheduler;

  logic        clk;
  logic        rst;

  logic        a_start, a_abort, a_req, a_ack, a_done, a_ovd;
  logic [3:0]  a_idx, a_bills, a_ovd_cnt;
  logic [15:0] a_amount;
  logic        a_busy, a_run_done, a_aborted;
  logic [23:0] a_total;

  logic        b_start, b_abort, b_req, b_ack, b_done, b_ovd;
  logic [3:0]  b_idx, b_bills, b_ovd_cnt;
  logic [15:0] b_amount;
  logic        b_busy, b_run_done, b_aborted;
  logic [23:0] b_total;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  int amt     [16];
  bit ovd     [16];
  int ack_dly [16];
  bit no_done [16];
  int abort_idx;
  int mid_start_cyc;
  bit chk_idx;
  int cyc;

  billing_cycle_scheduler u_dut_a (
    .i_clk(clk), .i_rst(rst), .i_start(a_start), .i_abort(a_abort),
    .o_calc_req(a_req), .o_calc_idx(a_idx), .i_calc_ack(a_ack), .i_calc_done(a_done),
    .i_calc_amount(a_amount), .i_calc_overdue(a_ovd), .o_busy(a_busy),
    .o_run_done(a_run_done), .o_aborted(a_aborted), .o_total_amount(a_total),
    .o_bills_issued(a_bills), .o_overdue_cnt(a_ovd_cnt)
  );

  billing_cycle_scheduler #(.NUM_METERS(15)) u_dut_b (
    .i_clk(clk), .i_rst(rst), .i_start(b_start), .i_abort(b_abort),
    .o_calc_req(b_req), .o_calc_idx(b_idx), .i_calc_ack(b_ack), .i_calc_done(b_done),
    .i_calc_amount(b_amount), .i_calc_overdue(b_ovd), .o_busy(b_busy),
    .o_run_done(b_run_done), .o_aborted(b_aborted), .o_total_amount(b_total),
    .o_bills_issued(b_bills), .o_overdue_cnt(b_ovd_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Default datapath behaviour for instance A: amount 100*(idx+1), immediate ack/done
  task automatic cfg_a();
    for (int i = 0; i < 16; i++) begin
      amt[i] = 100 * (i + 1); ovd[i] = 1'b0; ack_dly[i] = 0; no_done[i] = 1'b0;
    end
    abort_idx = -1; mid_start_cyc = -1; chk_idx = 1'b0;
  endtask

  // One run on A; cyc_out = clock edges from the start-sampling edge to run_done seen high
  task automatic run_a(output int cyc_out);
    int exp_idx, ack_wait, pidx, c;
    bit pending;
    exp_idx = 0; ack_wait = 0; pidx = 0; pending = 1'b0;
    a_start = 1'b1;
    @(posedge clk); #1;
    a_start = 1'b0; c = 1;
    while (!a_run_done && c < 3000) begin
      a_ack = 1'b0; a_done = 1'b0; a_abort = 1'b0;
      a_start = (c == mid_start_cyc);
      if (a_req) begin
        pending = 1'b0;
        if (chk_idx) check("idx_hold", 32'(a_idx), 32'(exp_idx));
        if (ack_wait >= ack_dly[exp_idx]) begin
          a_ack = 1'b1; pending = 1'b1; pidx = exp_idx; exp_idx++; ack_wait = 0;
        end else begin
          ack_wait++;
        end
      end else if (pending) begin
        pending = 1'b0;
        if (pidx == abort_idx) begin
          a_abort = 1'b1;
        end else if (!no_done[pidx]) begin
          a_done = 1'b1; a_amount = 16'(amt[pidx]); a_ovd = ovd[pidx];
        end
      end
      @(posedge clk); #1;
      c++;
    end
    a_ack = 1'b0; a_done = 1'b0; a_abort = 1'b0; a_start = 1'b0;
    cyc_out = c;
    check("a_run_done_seen", 32'(a_run_done), 32'd1);
    check("a_busy_at_done", 32'(a_busy), 32'd0);
    check("a_req_at_done", 32'(a_req), 32'd0);
    @(posedge clk); #1;
    check("a_run_done_pulse", 32'(a_run_done), 32'd0);
  endtask

  // Run on B with immediate handshake and amount 16'hFFFF; stops at run_done or max_cyc
  task automatic run_b(input int max_cyc, output int cyc_out);
    int c;
    bit pending;
    pending = 1'b0;
    b_start = 1'b1;
    @(posedge clk); #1;
    b_start = 1'b0; c = 1;
    while (!b_run_done && c < max_cyc) begin
      b_ack = 1'b0; b_done = 1'b0;
      if (b_req) begin
        b_ack = 1'b1; pending = 1'b1;
      end else if (pending) begin
        b_done = 1'b1; pending = 1'b0;
      end
      @(posedge clk); #1;
      c++;
    end
    b_ack = 1'b0; b_done = 1'b0;
    cyc_out = c;
  endtask

  initial begin
    rst = 1'b1;
    a_start = 0; a_abort = 0; a_ack = 0; a_done = 0; a_amount = '0; a_ovd = 0;
    b_start = 0; b_abort = 0; b_ack = 0; b_done = 0; b_amount = 16'hFFFF; b_ovd = 0;
    cfg_a();
    repeat (2) @(posedge clk);
    #1;
    // Reset state
    check("rst_req", 32'(a_req), 32'd0);
    check("rst_idx", 32'(a_idx), 32'd0);
    check("rst_busy", 32'(a_busy), 32'd0);
    check("rst_run_done", 32'(a_run_done), 32'd0);
    check("rst_aborted", 32'(a_aborted), 32'd0);
    check("rst_total", 32'(a_total), 32'd0);
    check("rst_bills", 32'(a_bills), 32'd0);
    check("rst_ovd_cnt", 32'(a_ovd_cnt), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Scenario 1: nominal run, 3*N+1 cycles
    cfg_a();
    run_a(cyc);
    check("s1_cycles", 32'(cyc), 32'd31);
    check("s1_total", 32'(a_total), 32'd5500);
    check("s1_bills", 32'(a_bills), 32'd10);
    check("s1_ovd_cnt", 32'(a_ovd_cnt), 32'd0);
    check("s1_aborted", 32'(a_aborted), 32'd0);

    // abort while idle has no effect
    a_abort = 1'b1;
    @(posedge clk); #1;
    a_abort = 1'b0;
    check("idle_abort_aborted", 32'(a_aborted), 32'd0);
    check("idle_abort_run_done", 32'(a_run_done), 32'd0);
    check("idle_abort_total", 32'(a_total), 32'd5500);

    // start together with abort does not begin a run
    a_start = 1'b1; a_abort = 1'b1;
    @(posedge clk); #1;
    a_start = 1'b0; a_abort = 1'b0;
    check("start_abort_busy", 32'(a_busy), 32'd0);
    check("start_abort_req", 32'(a_req), 32'd0);
    check("start_abort_bills", 32'(a_bills), 32'd10);

    // Scenario 4: idx 5 never completes -> skipped after 255 WAIT cycles
    cfg_a();
    no_done[5] = 1'b1;
    run_a(cyc);
    check("s4_cycles", 32'(cyc), 32'd284);
    check("s4_aborted", 32'(a_aborted), 32'd1);
    check("s4_bills", 32'(a_bills), 32'd9);
    check("s4_total", 32'(a_total), 32'd4900);

    // Scenario 2: overdue on idx 3 and 7, all amounts 200 (aborted must clear on start)
    cfg_a();
    for (int i = 0; i < 16; i++) amt[i] = 200;
    ovd[3] = 1'b1; ovd[7] = 1'b1;
    run_a(cyc);
`ifdef OVERDUE_PENALTY_EN
    check("s2_total", 32'(a_total), 32'd2100);
`else
    check("s2_total", 32'(a_total), 32'd2000);
`endif
    check("s2_ovd_cnt", 32'(a_ovd_cnt), 32'd2);
    check("s2_bills", 32'(a_bills), 32'd10);
    check("s2_aborted", 32'(a_aborted), 32'd0);

    // Scenario 3: ack on idx 2 delayed 4 cycles; request and index held throughout
    cfg_a();
    ack_dly[2] = 4; chk_idx = 1'b1;
    run_a(cyc);
    check("s3_cycles", 32'(cyc), 32'd35);
    check("s3_total", 32'(a_total), 32'd5500);
    check("s3_bills", 32'(a_bills), 32'd10);

    // Scenario 5: abort in WAIT of idx 4, stray start mid-run
    cfg_a();
    abort_idx = 4; mid_start_cyc = 5;
    run_a(cyc);
    check("s5_cycles", 32'(cyc), 32'd15);
    check("s5_aborted", 32'(a_aborted), 32'd1);
    check("s5_bills", 32'(a_bills), 32'd4);
    check("s5_total", 32'(a_total), 32'd1000);

    // Scenario 6: 15 meters of 16'hFFFF, repeated 20 times, no wrap
    for (int r = 0; r < 20; r++) begin
      run_b(200, cyc);
      check("s6_run_done", 32'(b_run_done), 32'd1);
      check("s6_total", 32'(b_total), 32'h000E_FFF1);
      check("s6_bills", 32'(b_bills), 32'd15);
      if (r == 0) check("s6_cycles", 32'(cyc), 32'd46);
      @(posedge clk); #1;
    end

    // Async reset mid-run: outputs clear before any clock edge
    run_b(8, cyc);
    check("s6_midrun_busy", 32'(b_busy), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("arst_b_busy", 32'(b_busy), 32'd0);
    check("arst_b_req", 32'(b_req), 32'd0);
    check("arst_b_idx", 32'(b_idx), 32'd0);
    check("arst_b_total", 32'(b_total), 32'd0);
    check("arst_b_bills", 32'(b_bills), 32'd0);
    check("arst_b_aborted", 32'(b_aborted), 32'd0);
    check("arst_a_total", 32'(a_total), 32'd0);
    check("arst_a_aborted", 32'(a_aborted), 32'd0);
    #3;
    rst = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      check("post_rst_run_done", 32'(b_run_done), 32'd0);
    end
    check("post_rst_busy", 32'(b_busy), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
